// File: rtl/food_rand_gen.sv
// food_rand_gen: random food-cell generator feeding the food-box placer.
// A free-running 16-bit LFSR supplies 6-bit cell indices; out-of-range
// indices are rejected. Each request draws X then Y and presents them as a
// strobed X cycle followed by a held Y value.
module food_rand_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          GRID      = 10,
  parameter int          MIN_POS   = 20,
  parameter int          CELLS     = 44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eat,
  output logic [8:0] rand_num,
  output logic       rand_drive,
  output logic       busy
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [6:0]  CELLS_W  = 7'(CELLS);
  localparam logic [8:0]  GRID_W   = 9'(GRID);
  localparam logic [8:0]  MIN_W    = 9'(MIN_POS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICK_X = 2'd1,
    PICK_Y = 2'd2,
    EMIT   = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] lfsr_q;
  logic        pending_q;
  logic [8:0]  x_q;
  logic [8:0]  y_q;
  logic [8:0]  rand_num_q;
  logic        rand_drive_q;

  logic        lfsr_fb;
  logic [5:0]  cand_idx;
  logic        cand_ok;
  logic [8:0]  cand_pos;

  // Taps for x^16+x^14+x^13+x^11+1 (maximal length).
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Candidate cell from the current LFSR value; legal parameter sets keep
  // the pixel position within 9 bits, so no clamp is needed.
  assign cand_idx = lfsr_q[5:0];
  assign cand_ok  = ({1'b0, cand_idx} < CELLS_W);
  assign cand_pos = MIN_W + 9'(cand_idx) * GRID_W;

  // LFSR free-runs in every state so draw timing is independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  // Request FSM: draw X, draw Y, strobe X, then present Y. A request seen
  // while busy is parked in a single merged pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      rand_num_q   <= '0;
      rand_drive_q <= 1'b0;
    end else begin
      if (eat && (state_q != IDLE)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (eat || pending_q) begin
            state_q   <= PICK_X;
            pending_q <= 1'b0;
          end
        end
        PICK_X: begin
          if (cand_ok) begin
            x_q     <= cand_pos;
            state_q <= PICK_Y;
          end
        end
        PICK_Y: begin
          if (cand_ok) begin
            rand_num_q   <= x_q;
            rand_drive_q <= 1'b1;
            y_q          <= cand_pos;
            state_q      <= EMIT;
          end
        end
        EMIT: begin
          rand_num_q   <= y_q;
          rand_drive_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rand_num   = rand_num_q;
  assign rand_drive = rand_drive_q;
  assign busy       = (state_q != IDLE) | pending_q;

endmodule
